// File: rtl/counter_updown_mod.sv
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Up/down counter with programmable modulus, parallel load,
//            synchronous clear and a registered wrap pulse. When the macro
//            COUNTER_SATURATE_EN is defined, the counter saturates at the
//            terminal values instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_updown_mod #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] c_max  = MAX_VAL;
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_is_max;
  logic             w_is_zero;

  assign w_is_max  = (r_q == c_max);
  assign w_is_zero = (r_q == c_zero);

  // Boundary tests precede the arithmetic so q never leaves 0..MAX_VAL,
  // even when MAX_VAL is all ones.
  always_comb begin
    w_next = r_q;
    w_wrap = 1'b0;
    if (clear) begin
      w_next = c_zero;
    end else if (load) begin
      w_next = (load_val > c_max) ? c_max : load_val;
    end else if (enable) begin
      if (up) begin
        if (w_is_max) begin
`ifdef COUNTER_SATURATE_EN
          w_next = c_max;
`else
          w_next = c_zero;
`endif
          w_wrap = 1'b1;
        end else begin
          w_next = r_q + c_one;
        end
      end else begin
        if (w_is_zero) begin
`ifdef COUNTER_SATURATE_EN
          w_next = c_zero;
`else
          w_next = c_max;
`endif
          w_wrap = 1'b1;
        end else begin
          w_next = r_q - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= c_zero;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_next;
      r_wrap <= w_wrap;
    end
  end

  assign q       = r_q;
  assign wrap    = r_wrap;
  assign at_max  = w_is_max;
  assign at_zero = w_is_zero;

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// ============================================================================
// Module   : tb_counter_updown_mod
// Purpose  : Directed self-checking bench for counter_updown_mod (4-bit mod-10
//            instance and 8-bit full-range instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_updown_mod;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset_n, a_clear, a_load, a_enable, a_up;
  logic [3:0] a_load_val, a_q;
  logic       a_wrap, a_at_max, a_at_zero;

  logic       b_reset_n, b_clear, b_load, b_enable, b_up;
  logic [7:0] b_load_val, b_q;
  logic       b_wrap, b_at_max, b_at_zero;

  int checks = 0;
  int errors = 0;

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9)) dut4 (
    .clk(clk), .reset_n(a_reset_n), .clear(a_clear), .load(a_load),
    .load_val(a_load_val), .enable(a_enable), .up(a_up),
    .q(a_q), .wrap(a_wrap), .at_max(a_at_max), .at_zero(a_at_zero)
  );

  counter_updown_mod #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(b_reset_n), .clear(b_clear), .load(b_load),
    .load_val(b_load_val), .enable(b_enable), .up(b_up),
    .q(b_q), .wrap(b_wrap), .at_max(b_at_max), .at_zero(b_at_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int eq, input bit ew);
    chk({tag, ".q"},       {28'd0, a_q},  eq);
    chk({tag, ".wrap"},    {31'd0, a_wrap}, {31'd0, ew});
    chk({tag, ".at_max"},  {31'd0, a_at_max},  {31'd0, (eq == 9)});
    chk({tag, ".at_zero"}, {31'd0, a_at_zero}, {31'd0, (eq == 0)});
  endtask

  task automatic chk8(input string tag, input int eq, input bit ew);
    chk({tag, ".q"},       {24'd0, b_q},  eq);
    chk({tag, ".wrap"},    {31'd0, b_wrap}, {31'd0, ew});
    chk({tag, ".at_max"},  {31'd0, b_at_max},  {31'd0, (eq == 255)});
    chk({tag, ".at_zero"}, {31'd0, b_at_zero}, {31'd0, (eq == 0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t_up_q[12];
  bit t_up_w[12];
  int t_dn_q[5];
  bit t_dn_w[5];

  initial begin
    if (SAT) begin
      t_up_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
      t_up_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      t_dn_q = '{2, 1, 0, 0, 0};
      t_dn_w = '{0, 0, 0, 1, 1};
    end else begin
      t_up_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      t_up_w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      t_dn_q = '{2, 1, 0, 9, 8};
      t_dn_w = '{0, 0, 0, 1, 0};
    end

    a_reset_n = 1'b0; a_clear = 1'b0; a_load = 1'b0; a_enable = 1'b0;
    a_up = 1'b0; a_load_val = 4'd0;
    b_reset_n = 1'b0; b_clear = 1'b0; b_load = 1'b0; b_enable = 1'b0;
    b_up = 1'b0; b_load_val = 8'd0;

    // Reset state
    #2;
    chk4("reset4", 0, 1'b0);
    chk8("reset8", 0, 1'b0);
    #10;
    a_reset_n = 1'b1;
    b_reset_n = 1'b1;

    // Count up through the modulus
    a_enable = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk4($sformatf("up%0d", i), t_up_q[i], t_up_w[i]);
    end

    // Load 3 with enable also high: load wins, then count down
    a_load = 1'b1; a_load_val = 4'd3; a_up = 1'b0;
    tick();
    chk4("load3", 3, 1'b0);
    a_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk4($sformatf("dn%0d", i), t_dn_q[i], t_dn_w[i]);
    end

    // Clamp of an out-of-range load value
    a_enable = 1'b0; a_load = 1'b1; a_load_val = 4'd14;
    tick();
    chk4("clamp14", 9, 1'b0);
    a_load = 1'b0;
    tick();
    chk4("hold9", 9, 1'b0);

    // clear beats load and enable
    a_load = 1'b1; a_load_val = 4'd5;
    tick();
    chk4("load5", 5, 1'b0);
    a_clear = 1'b1; a_load_val = 4'd7; a_enable = 1'b1; a_up = 1'b1;
    tick();
    chk4("clrprio", 0, 1'b0);
    a_clear = 1'b0;
    tick();
    chk4("loadprio", 7, 1'b0);
    a_load = 1'b0; a_enable = 1'b0;

    // Direction change mid-count
    a_enable = 1'b1; a_up = 1'b1;
    tick();
    chk4("dir_up", 8, 1'b0);
    a_up = 1'b0;
    tick();
    chk4("dir_dn", 7, 1'b0);
    tick();
    chk4("dir_dn2", 6, 1'b0);
    a_enable = 1'b0;
    tick();
    chk4("hold6", 6, 1'b0);

    // Asynchronous reset between edges while q=6
    #2;
    a_reset_n = 1'b0;
    #1;
    chk4("areset6", 0, 1'b0);
    #2;
    a_reset_n = 1'b1;
    a_enable = 1'b1; a_up = 1'b1;
    tick();
    chk4("resume", 1, 1'b0);

    // Async reset clears a live wrap pulse
    a_up = 1'b0; a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    tick();
    chk4("wrapdn", SAT ? 0 : 9, 1'b1);
    #1;
    a_reset_n = 1'b0;
    #1;
    chk4("areset_wrap", 0, 1'b0);
    a_reset_n = 1'b1;
    a_enable = 1'b0;

    // Terminal behaviour from 8 counting up, then down at 0
    a_load = 1'b1; a_load_val = 4'd8;
    tick();
    a_load = 1'b0; a_enable = 1'b1; a_up = 1'b1;
    tick();
    chk4("sat_up0", 9, 1'b0);
    tick();
    chk4("sat_up1", SAT ? 9 : 0, 1'b1);
    tick();
    chk4("sat_up2", SAT ? 9 : 1, SAT);
    a_enable = 1'b0; a_clear = 1'b1;
    tick();
    a_clear = 1'b0; a_enable = 1'b1; a_up = 1'b0;
    tick();
    chk4("sat_dn0", SAT ? 0 : 9, 1'b1);
    a_enable = 1'b0;

    // 8-bit full-range boundary
    b_load = 1'b1; b_load_val = 8'd255;
    tick();
    chk8("b_load255", 255, 1'b0);
    b_load = 1'b0; b_enable = 1'b1; b_up = 1'b1;
    tick();
    chk8("b_wrapup", SAT ? 255 : 0, 1'b1);
    b_up = 1'b0;
    tick();
    chk8("b_wrapdn", SAT ? 254 : 255, SAT ? 1'b0 : 1'b1);
    tick();
    chk8("b_dn", SAT ? 253 : 254, 1'b0);
    b_enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear and a registered wrap pulse. It is the general-purpose successor to the fixed 4-bit up-counter. It serves as the shared timebase, divider and event counter for datapath and control blocks in the same clock domain.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL; must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear to 0; highest synchronous priority.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value to load; values above MAX_VAL are clamped to MAX_VAL.
- enable  input  1  count step enable.
- up  input  1  direction: 1 counts up, 0 counts down; sampled only when a step occurs.
- q  output  WIDTH  current count, registered.
- wrap  output  1  registered one-cycle pulse marking a boundary crossing (see Operation).
- at_max  output  1  combinational: q == MAX_VAL.
- at_zero  output  1  combinational: q == 0.

## Operation
- Reset (reset_n low, asynchronous): q = 0 and wrap = 0 immediately. Because q = 0, at_zero = 1 and at_max = 0.
- Priority per rising edge is clear > load > enable. When none of them is asserted, q holds and wrap = 0.
- clear: q ← 0, wrap ← 0. The load, enable and up inputs are ignored in that cycle.
- load: q ← min(load_val, MAX_VAL), wrap ← 0. enable is ignored in that cycle.
- enable with up = 1:
  - If q < MAX_VAL: q ← q + 1.
  - If q == MAX_VAL: q ← 0 and wrap ← 1.
- enable with up = 0:
  - If q > 0: q ← q − 1.
  - If q == 0: q ← MAX_VAL and wrap ← 1.
- wrap is 0 on every edge that does not cross a boundary. It is never sticky.
- Arithmetic is done at WIDTH bits. The compare against MAX_VAL happens before the increment, so q never holds a value outside 0..MAX_VAL, including when MAX_VAL = 2**WIDTH-1.
- Changing direction mid-count is legal. The next step uses the new value of up, with no extra latency.

## Timing
- Latency is one cycle: q and wrap reflect an input sampled at edge N immediately after edge N.
- wrap is high for exactly the cycle in which q shows the wrapped value: 0 when counting up, MAX_VAL when counting down.
- at_max and at_zero follow q combinationally, with no cycle of delay.
- If reset_n is asserted mid-count, q and wrap clear without waiting for clk. The first step after deassertion is taken at the first rising edge that sees reset_n high and enable asserted.
- The only asynchronous input is reset_n. The synchronisation scheme for reset_n deassertion belongs to the integrator.

## Configuration
- Macro: COUNTER_SATURATE_EN.
- Undefined (default): modulo wrap-around behaviour exactly as described in Operation.
- Defined: saturating mode.
  - Counting up at MAX_VAL holds q at MAX_VAL.
  - Counting down at 0 holds q at 0.
  - In both cases wrap pulses for one cycle to flag the rejected step.
- clear, load, priority and reset behaviour are identical in both builds.

## Test plan
1. WIDTH=4, MAX_VAL=9, reset_n low, then released, then enable=1, up=1 for 12 cycles → q reads 0,1,…,9,0,1. wrap is high only in the cycle where q=0 after 9. at_max is high exactly while q=9.
2. WIDTH=4, MAX_VAL=9, load=1 with load_val=3, then enable=1, up=0 for 5 cycles → q reads 3,2,1,0,9,8. wrap is high only with q=9. load_val=14 → q=9 (clamped).
3. clear, load and enable all asserted together with q=5 → q=0 and wrap=0. With load and enable both asserted and load_val=7 → q=7 and no step is taken.
4. WIDTH=8, default MAX_VAL, q=255, enable=1, up=1 → q=0 and wrap=1. Then up=0 → q=255 and wrap=1. No out-of-range value ever appears.
5. Assert reset_n low between clock edges while q=6 → q=0 and wrap=0 before the next edge. After release, counting resumes from 0.
6. Build with COUNTER_SATURATE_EN, MAX_VAL=9:
   - Counting up from 8 for 3 cycles → q reads 9,9,9, with wrap high in the 2nd and 3rd cycles.
   - Counting down from 0 → q stays 0 and wrap=1.
